// File: rtl/mul_unit_if.sv
// Handshake and data bundle between the EX controller and the multiplier.
// Carries start/mulctl/rs1/rs2 in; busy/mul_done/mul_res out.
interface mul_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [1:0]      mulctl;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            busy;
  logic            mul_done;
  logic [XLEN-1:0] mul_res;

  modport master (
    output start, mulctl, rs1, rs2,
    input  busy, mul_done, mul_res
  );

  modport slave (
    input  start, mulctl, rs1, rs2,
    output busy, mul_done, mul_res
  );
endinterface

// File: rtl/mul_unit.sv
// Iterative radix-2 shift-add RV32M multiplier (mul/mulh/mulhsu/mulhu).
// Ports: clk, rst (async high), mu (slave: start/mulctl/rs1/rs2 -> busy/mul_done/mul_res).
module mul_unit #(
  parameter int XLEN = 32
) (
  input logic     clk,
  input logic     rst,
  mul_unit_if.slave mu
);
  localparam int PW = 2 * XLEN;
  localparam int CW = $clog2(XLEN);
  localparam logic [PW-1:0]   ONE_P = PW'(1);
  localparam logic [XLEN-1:0] ONE_X = XLEN'(1);
  localparam logic [CW-1:0]   LAST  = CW'(XLEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FINISH
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [1:0]      ctl_q;
  logic            neg_q;
  logic [PW-1:0]   mcand_q;
  logic [XLEN-1:0] mplier_q;
  logic [PW-1:0]   acc_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] res_q;
  logic            done_q;

  logic            sgn1;
  logic            sgn2;
  logic            neg1;
  logic            neg2;
  logic [XLEN-1:0] abs1;
  logic [XLEN-1:0] abs2;
  logic [PW-1:0]   prod;

  always_comb begin
    sgn1 = 1'b0;
    sgn2 = 1'b0;
    unique case (1'b1)
      (mu.mulctl == 2'b01): begin
        sgn1 = 1'b1;
        sgn2 = 1'b1;
      end
      (mu.mulctl == 2'b10): sgn1 = 1'b1;
      default: ;
    endcase
  end

  // |-2^(XLEN-1)| wraps to itself, which is the right unsigned magnitude
  assign neg1 = sgn1 & mu.rs1[XLEN-1];
  assign neg2 = sgn2 & mu.rs2[XLEN-1];
  assign abs1 = neg1 ? (~mu.rs1 + ONE_X) : mu.rs1;
  assign abs2 = neg2 ? (~mu.rs2 + ONE_X) : mu.rs2;
  assign prod = neg_q ? (~acc_q + ONE_P) : acc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (mu.start) state_d = CALC;
      CALC:    if (cnt_q == LAST) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_q    <= '0;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (mu.start) begin
            ctl_q    <= mu.mulctl;
            neg_q    <= neg1 ^ neg2;
            mcand_q  <= {{XLEN{1'b0}}, abs1};
            mplier_q <= abs2;
            acc_q    <= '0;
            cnt_q    <= '0;
          end
        end
        CALC: begin
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
        end
        FINISH: begin
          res_q  <= (ctl_q == 2'b00) ? prod[XLEN-1:0]
                                     : prod[PW-1:XLEN];
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mu.busy     = (state_q != IDLE);
  assign mu.mul_done = done_q;
  assign mu.mul_res  = res_q;
endmodule

// File: tb/tb_mul_unit.sv
// Scoreboard bench for mul_unit: results and start cycles queued at issue,
// popped and checked (value, latency, busy length) when mul_done fires.
module tb_mul_unit;
  logic clk;
  logic rst;
  int   cyc;
  int   n_cmp;
  int   n_err;
  int   busy_cnt;

  logic [31:0] exp_q[$];
  int          t_q[$];

  mul_unit_if #(.XLEN(32)) mu ();

  mul_unit #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .mu  (mu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model(logic [1:0] c,
                                        logic [31:0] a,
                                        logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] p;
    ea = (c == 2'b01 || c == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
    eb = (c == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ea * eb;
    return (c == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Monitor: sample #1 after each rising edge
  always @(posedge clk) begin
    #1;
    if (rst) begin
      busy_cnt = 0;
    end else begin
      if (mu.busy) busy_cnt++;
      if (exp_q.size() == 0) begin
        chk("no_done", {63'b0, mu.mul_done}, 64'd0);
      end else if (mu.mul_done) begin
        chk("mul_res", {32'b0, mu.mul_res}, {32'b0, exp_q.pop_front()});
        chk("latency", 64'(cyc - t_q.pop_front()), 64'd33);
        chk("busy_len", 64'(busy_cnt), 64'd33);
        busy_cnt = 0;
      end
    end
  end

  // Caller must be at a falling edge; returns at the next falling edge
  task automatic issue(logic [1:0] c, logic [31:0] a,
                       logic [31:0] b, logic [31:0] e);
    mu.start  = 1'b1;
    mu.mulctl = c;
    mu.rs1    = a;
    mu.rs2    = b;
    exp_q.push_back(e);
    t_q.push_back(cyc + 1);
    @(negedge clk);
    mu.start  = 1'b0;
    mu.mulctl = 2'($urandom_range(3));
    mu.rs1    = $urandom();
    mu.rs2    = $urandom();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    t_q.delete();
  endtask

  initial begin
    logic [1:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    n_cmp     = 0;
    n_err     = 0;
    busy_cnt  = 0;
    rst       = 1'b1;
    mu.start  = 1'b0;
    mu.mulctl = 2'b00;
    mu.rs1    = '0;
    mu.rs2    = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'b0, mu.busy}, 64'd0);
    chk("rst_done", {63'b0, mu.mul_done}, 64'd0);
    chk("rst_res", {32'b0, mu.mul_res}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(2'b00, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    drain();
    issue(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    drain();
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    drain();
    issue(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drain();
    issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    drain();
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    drain();
    issue(2'b00, 32'd0, 32'h1234_5678, 32'd0);
    drain();

    // start while busy is ignored
    issue(2'b11, 32'd2, 32'd2, 32'd0);
    repeat (8) @(negedge clk);
    mu.start  = 1'b1;
    mu.mulctl = 2'b11;
    mu.rs1    = 32'd3;
    mu.rs2    = 32'd3;
    @(negedge clk);
    mu.start  = 1'b0;
    drain();
    repeat (40) @(negedge clk);

    // reset mid-operation
    issue(2'b00, 32'd9, 32'd9, 32'd81);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    t_q.delete();
    #1;
    chk("midrst_busy", {63'b0, mu.busy}, 64'd0);
    chk("midrst_done", {63'b0, mu.mul_done}, 64'd0);
    chk("midrst_res", {32'b0, mu.mul_res}, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    issue(2'b00, 32'd9, 32'd9, 32'd81);
    drain();

    // start in the mul_done cycle
    issue(2'b00, 32'h1234, 32'h10, 32'h12340);
    drain();
    issue(2'b00, 32'd5, 32'd6, 32'h1E);
    for (int i = 0; i < 31; i++) begin
      chk("held", {32'b0, mu.mul_res}, 64'h12340);
      @(negedge clk);
    end
    drain();

    for (int i = 0; i < 10; i++) begin
      c = 2'($urandom_range(3));
      a = $urandom();
      b = $urandom();
      if (i == 0) a = 32'h8000_0000;
      if (i == 1) b = 32'h8000_0000;
      issue(c, a, b, model(c, a, b));
      drain();
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
